// File: rtl/pdm_dac_bank.sv
// Multi-channel SPI-fed PDM DAC: addressed samples land in per-channel pending
// registers, a commit flag copies them all to active, and each active value drives a delta-sigma modulator.
module pdm_dac_bank #(
    parameter int SAMPLE_W = 16,
    parameter int NUM_CH   = 2,
    parameter int ORDER    = 1,
    parameter int PDM_DIV  = 1
) (
    input  logic              input_clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_done,
    output logic              frame_err,
    input  logic              mute,
    output logic [NUM_CH-1:0] dac_pdm_out
);
    localparam int FRAME_W = 8 + SAMPLE_W;
    localparam int CNT_W   = 6;
    // The bit counter saturates at 31 unless a full frame cannot fit below that.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((FRAME_W < 31) ? 31 : FRAME_W + 1);
    localparam int DIV_W   = $clog2(PDM_DIV + 1);

    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            cs_sync   <= {cs_sync[1:0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low, mosi_bit;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_low    = ~cs_sync[1];
    assign mosi_bit  = mosi_sync[1];

    logic               armed;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic [6:0]         status_sr;
    logic               err_seen;
    logic               stale;

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            status_sr <= '0;
            err_seen  <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            if (cs_sync[1]) armed <= 1'b1;
            if (cs_fall) begin
                bit_cnt   <= '0;
                spi_miso  <= frame_err;
                status_sr <= {stale, 6'b0};
                err_seen  <= frame_err;
            end else if (cs_low) begin
                if (sclk_rise) begin
                    shift_reg <= {shift_reg[FRAME_W-2:0], mosi_bit};
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                end
                if (sclk_fall) begin
                    spi_miso  <= status_sr[6];
                    status_sr <= {status_sr[5:0], 1'b0};
                end
            end else begin
                spi_miso <= 1'b0;
            end
        end
    end

    logic                hdr_commit;
    logic [3:0]          hdr_ch;
    logic [SAMPLE_W-1:0] hdr_sample;
    logic                frame_ok, accept, reject;
    logic                unused_rsvd;

    assign hdr_commit  = shift_reg[FRAME_W-1];
    assign hdr_ch      = shift_reg[FRAME_W-5:FRAME_W-8];
    assign hdr_sample  = shift_reg[SAMPLE_W-1:0];
    assign unused_rsvd = ^shift_reg[FRAME_W-2:FRAME_W-4];
    assign frame_ok    = (bit_cnt == CNT_W'(FRAME_W)) && ({1'b0, hdr_ch} < 5'(NUM_CH));
    // Frames that started before the receiver was armed are dropped silently.
    assign accept      = cs_rise & armed & frame_ok;
    assign reject      = cs_rise & armed & ~frame_ok;

    logic [SAMPLE_W-1:0] pending [NUM_CH];
    logic [SAMPLE_W-1:0] active  [NUM_CH];
    logic [NUM_CH-1:0]   dirty;

    assign stale = |dirty;

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: pending/active are small flop arrays, not RAM, so they take the async reset like any other state.
            for (int i = 0; i < NUM_CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
            dirty     <= '0;
            spi_done  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            spi_done <= accept;
            if (accept) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (hdr_ch == 4'(i)) pending[i] <= hdr_sample;
                    if (hdr_commit) active[i] <= (hdr_ch == 4'(i)) ? hdr_sample : pending[i];
                end
                if (hdr_commit) dirty <= '0;
                else            dirty[hdr_ch[$clog2(NUM_CH+1)-1:0]] <= 1'b1;
                if (err_seen) frame_err <= 1'b0;
            end
            if (reject) frame_err <= 1'b1;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    assign tick = (div_cnt == DIV_W'(PDM_DIV - 1));

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic signed [SAMPLE_W-1:0] x;
        logic                       pdm_q;
        assign x = mute ? '0 : active[ch];
        assign dac_pdm_out[ch] = pdm_q;

        if (ORDER == 1) begin : g_o1
            logic [SAMPLE_W-1:0] acc;
            logic [SAMPLE_W:0]   sum;
            assign sum = {1'b0, acc} + {1'b0, ~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};

            always_ff @(posedge input_clk or negedge reset_n) begin
                if (!reset_n) begin
                    acc   <= '0;
                    pdm_q <= 1'b0;
                end else if (tick) begin
                    acc   <= sum[SAMPLE_W-1:0];
                    pdm_q <= sum[SAMPLE_W];
                end
            end
        end else begin : g_o2
            localparam int INT_W = SAMPLE_W + 4;
            localparam logic signed [INT_W+1:0] I_MAX  = (INT_W+2)'((1 << (INT_W-1)) - 1);
            localparam logic signed [INT_W+1:0] I_MIN  = -(INT_W+2)'(1 << (INT_W-1));
            localparam logic signed [INT_W+1:0] FB_POS = (INT_W+2)'(1 << (SAMPLE_W-1));

            function automatic logic signed [INT_W-1:0] sat(input logic signed [INT_W+1:0] v);
                if (v > I_MAX)      return I_MAX[INT_W-1:0];
                else if (v < I_MIN) return I_MIN[INT_W-1:0];
                else                return v[INT_W-1:0];
            endfunction

            logic signed [INT_W-1:0] i1, i2, i1_new, i2_new;
            logic signed [INT_W+1:0] fb, x_ext, s1, s2;

            assign fb     = pdm_q ? FB_POS : -FB_POS;
            assign x_ext  = {{(INT_W+2-SAMPLE_W){x[SAMPLE_W-1]}}, x};
            assign s1     = {{2{i1[INT_W-1]}}, i1} + x_ext - fb;
            assign i1_new = sat(s1);
            assign s2     = {{2{i2[INT_W-1]}}, i2} + {{2{i1_new[INT_W-1]}}, i1_new} - fb;
            assign i2_new = sat(s2);

            always_ff @(posedge input_clk or negedge reset_n) begin
                if (!reset_n) begin
                    i1    <= '0;
                    i2    <= '0;
                    pdm_q <= 1'b0;
                end else if (tick) begin
                    i1    <= i1_new;
                    i2    <= i2_new;
                    pdm_q <= ~i2_new[INT_W-1];
                end
            end
        end
    end
endmodule
